// File: rtl/alu_arbiter_if.sv
// Requester-side channel of alu_arbiter: request handshake plus response handshake.
// The arbiter takes the slave modport; each requester takes the master modport.
interface alu_arbiter_if #(
  parameter int TAG_WIDTH = 4,
  parameter int CTL_WIDTH = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [CTL_WIDTH-1:0] req_alu_ctl;
  logic [31:0]          req_op1;
  logic [31:0]          req_op2;
  logic [TAG_WIDTH-1:0] req_tag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_result;
  logic                 rsp_branch_outcome;
  logic [TAG_WIDTH-1:0] rsp_tag;

  modport master (
    output req_valid, req_alu_ctl, req_op1, req_op2, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_branch_outcome, rsp_tag
  );

  modport slave (
    input  req_valid, req_alu_ctl, req_op1, req_op2, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_branch_outcome, rsp_tag
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter feeding a shared combinational ALU through an
// issue/response pipeline. Optional grant counters enabled by macro ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int TAG_WIDTH = 4,
  parameter int CTL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_arbiter_if.slave         ch0,
  alu_arbiter_if.slave         ch1,
  output logic                 alu_valid,
  output logic [CTL_WIDTH-1:0] alu_ctl,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  input  logic                 alu_res_valid,
  input  logic [31:0]          alu_result,
  input  logic                 alu_branch_outcome,
  input  logic                 alu_done,
  output logic                 done_sticky,
  output logic [31:0]          grant_cnt0,
  output logic [31:0]          grant_cnt1
);

  typedef enum logic {OWNER0 = 1'b0, OWNER1 = 1'b1} owner_e;

  logic                 i_valid;
  owner_e               i_owner;
  logic [CTL_WIDTH-1:0] i_ctl;
  logic [31:0]          i_op1;
  logic [31:0]          i_op2;
  logic [TAG_WIDTH-1:0] i_tag;

  logic                 r_valid;
  owner_e               r_owner;
  logic [31:0]          r_result;
  logic                 r_outcome;
  logic [TAG_WIDTH-1:0] r_tag;

  owner_e               ptr;
  owner_e               grant_sel;
  logic                 owner_ready;
  logic                 r_adv;
  logic                 can_load;
  logic                 grant;
  logic [CTL_WIDTH-1:0] sel_ctl;
  logic [31:0]          sel_op1;
  logic [31:0]          sel_op2;
  logic [TAG_WIDTH-1:0] sel_tag;

  always_comb begin
    owner_ready = (r_owner == OWNER1) ? ch1.rsp_ready : ch0.rsp_ready;
    r_adv       = !r_valid || owner_ready;
    // I only ever advances together with R, so it can take a new op when empty or when R moves.
    can_load    = rst_n && !done_sticky && (!i_valid || r_adv);

    if (ch0.req_valid && ch1.req_valid) grant_sel = ptr;
    else if (ch1.req_valid)             grant_sel = OWNER1;
    else                                grant_sel = OWNER0;

    grant         = can_load && (ch0.req_valid || ch1.req_valid);
    ch0.req_ready = grant && (grant_sel == OWNER0);
    ch1.req_ready = grant && (grant_sel == OWNER1);

    sel_ctl = (grant_sel == OWNER1) ? ch1.req_alu_ctl : ch0.req_alu_ctl;
    sel_op1 = (grant_sel == OWNER1) ? ch1.req_op1     : ch0.req_op1;
    sel_op2 = (grant_sel == OWNER1) ? ch1.req_op2     : ch0.req_op2;
    sel_tag = (grant_sel == OWNER1) ? ch1.req_tag     : ch0.req_tag;
  end

  always_comb begin
    alu_valid = i_valid;
    alu_ctl   = i_ctl;
    alu_op1   = i_op1;
    alu_op2   = i_op2;

    ch0.rsp_valid          = r_valid && (r_owner == OWNER0);
    ch0.rsp_result         = r_result;
    ch0.rsp_branch_outcome = r_outcome;
    ch0.rsp_tag            = r_tag;
    ch1.rsp_valid          = r_valid && (r_owner == OWNER1);
    ch1.rsp_result         = r_result;
    ch1.rsp_branch_outcome = r_outcome;
    ch1.rsp_tag            = r_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_valid     <= 1'b0;
      r_valid     <= 1'b0;
      ptr         <= OWNER0;
      done_sticky <= 1'b0;
    end else begin
      if (i_valid && alu_done) done_sticky <= 1'b1;

      if (r_adv) begin
        r_valid   <= i_valid && alu_res_valid;
        r_owner   <= i_owner;
        r_result  <= alu_result;
        r_outcome <= alu_branch_outcome;
        r_tag     <= i_tag;
      end

      if (grant) begin
        i_valid <= 1'b1;
        i_owner <= grant_sel;
        i_ctl   <= sel_ctl;
        i_op1   <= sel_op1;
        i_op2   <= sel_op2;
        i_tag   <= sel_tag;
        ptr     <= (grant_sel == OWNER0) ? OWNER1 : OWNER0;
      end else if (r_adv) begin
        i_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (ch0.req_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (ch1.req_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small combinational ALU model
// (ADD, SUB, BEQ, MTC0_DONE) attached to the shared ALU port.
module tb_alu_arbiter;
  localparam logic [3:0] ADD       = 4'd0;
  localparam logic [3:0] SUB       = 4'd1;
  localparam logic [3:0] BEQ       = 4'd2;
  localparam logic [3:0] MTC0_DONE = 4'd3;
  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;
`ifdef ALU_ARB_STATS_EN
  localparam logic [31:0] EXP_CNT0 = 32'd5;
  localparam logic [31:0] EXP_CNT1 = 32'd3;
`else
  localparam logic [31:0] EXP_CNT0 = 32'd0;
  localparam logic [31:0] EXP_CNT1 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_res_valid;
  logic [31:0] alu_result;
  logic        alu_branch_outcome;
  logic        alu_done;
  logic        done_sticky;
  logic [31:0] grant_cnt0, grant_cnt1;
  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.TAG_WIDTH(4), .CTL_WIDTH(4)) ch0 ();
  alu_arbiter_if #(.TAG_WIDTH(4), .CTL_WIDTH(4)) ch1 ();

  alu_arbiter #(.TAG_WIDTH(4), .CTL_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ch0(ch0), .ch1(ch1),
    .alu_valid(alu_valid), .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res_valid(alu_res_valid), .alu_result(alu_result),
    .alu_branch_outcome(alu_branch_outcome), .alu_done(alu_done),
    .done_sticky(done_sticky), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res_valid      = alu_valid;
    alu_result         = 32'd0;
    alu_branch_outcome = TAKEN;
    alu_done           = 1'b0;
    case (alu_ctl)
      ADD: alu_result = alu_op1 + alu_op2;
      SUB: alu_result = alu_op1 - alu_op2;
      BEQ: begin
        alu_result         = alu_op1 - alu_op2;
        alu_branch_outcome = (alu_op1 == alu_op2) ? TAKEN : NOT_TAKEN;
      end
      MTC0_DONE: alu_done = 1'b1;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    ch0.req_valid = v; ch0.req_alu_ctl = c; ch0.req_op1 = a; ch0.req_op2 = b; ch0.req_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    ch1.req_valid = v; ch1.req_alu_ctl = c; ch1.req_op1 = a; ch1.req_op2 = b; ch1.req_tag = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch0.req_valid = 1'b0; ch1.req_valid = 1'b0;
    ch0.rsp_ready = 1'b1; ch1.rsp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ch0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid: got %0b exp 0", ch0.rsp_valid); end
    checks++; if (ch1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid: got %0b exp 0", ch1.rsp_valid); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid: got %0b exp 0", alu_valid); end
    checks++; if (done_sticky !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b exp 0", done_sticky); end
    checks++; if (grant_cnt0 !== 32'd0) begin errors++; $display("FAIL reset_cnt0: got %0h exp 0", grant_cnt0); end
    drive1(1'b1, ADD, 32'd1, 32'd1, 4'd0);
    #1;
    checks++; if (ch1.req_ready !== 1'b1 || ch0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_single: got r0=%0b r1=%0b exp r0=0 r1=1", ch0.req_ready, ch1.req_ready); end
    ch1.req_valid = 1'b0;
  endtask

  task automatic test_single_add();
    do_reset();
    drive0(1'b1, ADD, 32'd5, 32'd7, 4'd3);
    #1;
    checks++; if (ch0.req_ready !== 1'b1) begin errors++; $display("FAIL add_ready0: got %0b exp 1", ch0.req_ready); end
    tick();
    ch0.req_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin errors++; $display("FAIL add_issue: got v=%0b op1=%0d op2=%0d exp v=1 op1=5 op2=7", alu_valid, alu_op1, alu_op2); end
    checks++; if (ch0.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp: got %0b exp 0", ch0.rsp_valid); end
    tick();
    checks++; if (ch0.rsp_valid !== 1'b1 || ch0.rsp_result !== 32'd12 || ch0.rsp_tag !== 4'd3) begin errors++; $display("FAIL add_rsp0: got v=%0b res=%0d tag=%0d exp v=1 res=12 tag=3", ch0.rsp_valid, ch0.rsp_result, ch0.rsp_tag); end
    checks++; if (ch1.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp1_quiet: got %0b exp 0", ch1.rsp_valid); end
    checks++; if (ch0.rsp_branch_outcome !== TAKEN) begin errors++; $display("FAIL add_outcome: got %0b exp 1", ch0.rsp_branch_outcome); end
    tick();
    checks++; if (ch0.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_clear: got %0b exp 0", ch0.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    logic exp0;
    do_reset();
    drive0(1'b1, ADD, 32'd1, 32'd1, 4'd0);
    drive1(1'b1, SUB, 32'd9, 32'd2, 4'd1);
    for (int k = 0; k < 8; k++) begin
      exp0 = (k % 2 == 0);
      #1;
      checks++; if (ch0.req_ready !== exp0 || ch1.req_ready !== !exp0) begin errors++; $display("FAIL rr_grant_%0d: got r0=%0b r1=%0b exp r0=%0b r1=%0b", k, ch0.req_ready, ch1.req_ready, exp0, !exp0); end
      tick();
      if (ch0.rsp_valid === 1'b1) n0++;
      if (ch1.rsp_valid === 1'b1) n1++;
    end
    ch0.req_valid = 1'b0; ch1.req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (ch0.rsp_valid === 1'b1) n0++;
      if (ch1.rsp_valid === 1'b1) n1++;
    end
    checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL rr_rsp_count: got n0=%0d n1=%0d exp 4 4", n0, n1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ch1.rsp_ready = 1'b0;
    drive1(1'b1, BEQ, 32'd9, 32'd9, 4'd5);
    #1;
    checks++; if (ch1.req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_beq: got %0b exp 1", ch1.req_ready); end
    tick();
    drive1(1'b1, ADD, 32'd4, 32'd6, 4'd6);
    #1;
    checks++; if (ch1.req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_add: got %0b exp 1", ch1.req_ready); end
    tick();
    ch1.req_valid = 1'b0;
    drive0(1'b1, ADD, 32'd1, 32'd1, 4'd7);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ch0.req_ready !== 1'b0 || ch1.req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready_%0d: got r0=%0b r1=%0b exp 0 0", k, ch0.req_ready, ch1.req_ready); end
      checks++; if (ch1.rsp_valid !== 1'b1 || ch1.rsp_result !== 32'd0 || ch1.rsp_tag !== 4'd5 || ch1.rsp_branch_outcome !== TAKEN) begin errors++; $display("FAIL bp_hold_%0d: got v=%0b res=%0d tag=%0d oc=%0b exp 1 0 5 1", k, ch1.rsp_valid, ch1.rsp_result, ch1.rsp_tag, ch1.rsp_branch_outcome); end
      tick();
    end
    ch1.rsp_ready = 1'b1;
    #1;
    checks++; if (ch0.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready0: got %0b exp 1", ch0.req_ready); end
    tick();
    ch0.req_valid = 1'b0;
    checks++; if (ch1.rsp_valid !== 1'b1 || ch1.rsp_result !== 32'd10 || ch1.rsp_tag !== 4'd6) begin errors++; $display("FAIL bp_second: got v=%0b res=%0d tag=%0d exp 1 10 6", ch1.rsp_valid, ch1.rsp_result, ch1.rsp_tag); end
    tick();
    checks++; if (ch0.rsp_valid !== 1'b1 || ch1.rsp_valid !== 1'b0 || ch0.rsp_result !== 32'd2 || ch0.rsp_tag !== 4'd7) begin errors++; $display("FAIL bp_third: got v0=%0b v1=%0b res=%0d tag=%0d exp 1 0 2 7", ch0.rsp_valid, ch1.rsp_valid, ch0.rsp_result, ch0.rsp_tag); end
  endtask

  task automatic test_done();
    do_reset();
    drive0(1'b1, MTC0_DONE, 32'd0, 32'd0, 4'd1);
    #1;
    checks++; if (ch0.req_ready !== 1'b1) begin errors++; $display("FAIL done_accept: got %0b exp 1", ch0.req_ready); end
    tick();
    ch0.req_valid = 1'b0;
    drive1(1'b1, ADD, 32'd3, 32'd4, 4'd2);
    #1;
    checks++; if (ch1.req_ready !== 1'b1 || done_sticky !== 1'b0) begin errors++; $display("FAIL done_queue_add: got r1=%0b done=%0b exp 1 0", ch1.req_ready, done_sticky); end
    tick();
    drive1(1'b1, ADD, 32'd8, 32'd8, 4'd3);
    #1;
    checks++; if (done_sticky !== 1'b1) begin errors++; $display("FAIL done_sticky_set: got %0b exp 1", done_sticky); end
    checks++; if (ch0.rsp_valid !== 1'b1 || ch0.rsp_result !== 32'd0 || ch0.rsp_tag !== 4'd1) begin errors++; $display("FAIL done_rsp: got v=%0b res=%0d tag=%0d exp 1 0 1", ch0.rsp_valid, ch0.rsp_result, ch0.rsp_tag); end
    checks++; if (ch1.req_ready !== 1'b0 || alu_valid !== 1'b1) begin errors++; $display("FAIL done_block: got r1=%0b alu_v=%0b exp 0 1", ch1.req_ready, alu_valid); end
    tick();
    checks++; if (ch1.rsp_valid !== 1'b1 || ch1.rsp_result !== 32'd7 || ch1.rsp_tag !== 4'd2) begin errors++; $display("FAIL done_drain: got v=%0b res=%0d tag=%0d exp 1 7 2", ch1.rsp_valid, ch1.rsp_result, ch1.rsp_tag); end
    tick();
    checks++; if (ch1.req_ready !== 1'b0 || alu_valid !== 1'b0 || ch1.rsp_valid !== 1'b0 || done_sticky !== 1'b1) begin errors++; $display("FAIL done_after: got r1=%0b alu_v=%0b rsp1=%0b done=%0b exp 0 0 0 1", ch1.req_ready, alu_valid, ch1.rsp_valid, done_sticky); end
    ch1.req_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    do_reset();
    ch0.rsp_ready = 1'b0;
    drive0(1'b1, ADD, 32'd1, 32'd2, 4'd1);
    tick();
    drive0(1'b1, ADD, 32'd2, 32'd3, 4'd2);
    tick();
    ch0.req_valid = 1'b0;
    checks++; if (ch0.rsp_valid !== 1'b1 || alu_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got rsp0=%0b alu_v=%0b exp 1 1", ch0.rsp_valid, alu_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ch0.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (ch0.rsp_valid !== 1'b0 || ch1.rsp_valid !== 1'b0 || alu_valid !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp: got %0d busy cycles exp 0", seen); end
    checks++; if (done_sticky !== 1'b0) begin errors++; $display("FAIL mid_done: got %0b exp 0", done_sticky); end
    drive0(1'b1, ADD, 32'd0, 32'd0, 4'd0);
    drive1(1'b1, ADD, 32'd0, 32'd0, 4'd0);
    #1;
    checks++; if (ch0.req_ready !== 1'b1 || ch1.req_ready !== 1'b0) begin errors++; $display("FAIL mid_ptr: got r0=%0b r1=%0b exp 1 0", ch0.req_ready, ch1.req_ready); end
    ch0.req_valid = 1'b0; ch1.req_valid = 1'b0;
  endtask

  task automatic test_stats();
    do_reset();
    drive0(1'b1, ADD, 32'd1, 32'd0, 4'd0);
    for (int k = 0; k < 5; k++) tick();
    ch0.req_valid = 1'b0;
    drive1(1'b1, SUB, 32'd1, 32'd0, 4'd0);
    for (int k = 0; k < 3; k++) tick();
    ch1.req_valid = 1'b0;
    tick(); tick();
    checks++; if (grant_cnt0 !== EXP_CNT0) begin errors++; $display("FAIL stats_cnt0: got %0d exp %0d", grant_cnt0, EXP_CNT0); end
    checks++; if (grant_cnt1 !== EXP_CNT1) begin errors++; $display("FAIL stats_cnt1: got %0d exp %0d", grant_cnt1, EXP_CNT1); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive0(1'b0, ADD, '0, '0, '0);
    drive1(1'b0, ADD, '0, '0, '0);
    ch0.rsp_ready = 1'b1;
    ch1.rsp_ready = 1'b1;
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_done();
    test_reset_midflight();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
